// File: rtl/strobe_pkg.sv
// Shared definitions for the strobe sequencer: FSM state encoding and default sizing.
package strobe_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int DLY_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    FIRE = 2'd3
  } state_t;

endpackage

// File: rtl/strobe_edge_detect.sv
// Per-channel edge detection feeding sticky pending and overrun flags.
module strobe_edge_detect
  import strobe_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] rx,
  input  logic            mode,
  input  logic            ovr_clr,
  input  logic [N_CH-1:0] pend_clr,
  output logic [N_CH-1:0] pend,
  output logic [N_CH-1:0] overrun
);

  logic [N_CH-1:0] rx_q;
  logic [N_CH-1:0] evt;
  logic [N_CH-1:0] ovr_set;

  always_comb begin
    evt     = mode ? (~rx_q & rx) : (rx_q & ~rx);
    // A clear and a new event in the same cycle merge into a fresh request, not a lost one.
    ovr_set = evt & pend & ~pend_clr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q    <= '0;
      pend    <= '0;
      overrun <= '0;
    end else begin
      rx_q    <= rx;
      pend    <= (pend & ~pend_clr) | evt;
      overrun <= (overrun & ~{N_CH{ovr_clr}}) | ovr_set;
    end
  end

endmodule

// File: rtl/strobe_sequencer.sv
// Round-robin load/start strobe sequencer with a programmable load-to-start gap.
module strobe_sequencer
  import strobe_pkg::*;
#(
  parameter  int N_CH  = N_CH_DEF,
  parameter  int DLY_W = DLY_W_DEF,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  rx,
  input  logic             mode,
  input  logic [DLY_W-1:0] delay,
  input  logic             ovr_clr,
  output logic             PULSE_LD,
  output logic             START,
  output logic [CH_W-1:0]  ch,
  output logic             busy,
  output logic [N_CH-1:0]  overrun
);

  state_t           state;
  logic [DLY_W-1:0] cnt;
  logic [CH_W-1:0]  rr;
  logic [CH_W-1:0]  sel;
  logic             found;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  pend_clr;
  int               idx;

  strobe_edge_detect #(
    .N_CH(N_CH)
  ) u_edge (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .mode    (mode),
    .ovr_clr (ovr_clr),
    .pend_clr(pend_clr),
    .pend    (pend),
    .overrun (overrun)
  );

  // First pending channel at or after rr, wrapping modulo N_CH.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    idx      = 0;
    pend_clr = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(rr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
    if (state == IDLE && found) pend_clr = N_CH'(1) << sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rr       <= '0;
      ch       <= '0;
      PULSE_LD <= 1'b0;
      START    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      PULSE_LD <= 1'b0;
      START    <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            ch       <= sel;
            state    <= LOAD;
            PULSE_LD <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          cnt <= delay;
          if (delay != '0) begin
            state <= WAIT;
          end else begin
            state <= FIRE;
            START <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt - DLY_W'(1);
          if (cnt <= DLY_W'(1)) begin
            state <= FIRE;
            START <= 1'b1;
          end
        end
        FIRE: begin
          rr    <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + CH_W'(1);
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
